// File: rtl/conv_job_scheduler.sv
// Round-robin scheduler sharing one convolution processor between NREQ requesters.
// Latches the winner's job sizes, launches the processor, and watches for hung jobs.
module conv_job_scheduler #(
    parameter int NREQ   = 2,
    parameter int SIZE_W = 5,
    parameter int TMO_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*SIZE_W-1:0]   sizeX_i,
    input  logic [NREQ*SIZE_W-1:0]   sizeY_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic                     conv_start_o,
    output logic [SIZE_W-1:0]        conv_sizeX_o,
    output logic [SIZE_W-1:0]        conv_sizeY_o,
    input  logic                     conv_busy_i,
    input  logic                     conv_done_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE, ARB, LAUNCH, RUN, FINISH, REJECT, TIMEOUT
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, rr_n;
    logic [TMO_W-1:0]  wd, wd_n;
    logic [NREQ-1:0]   grant_n, done_n;
    logic              err_n, start_n, busy_n;
    logic [SIZE_W-1:0] sx_n, sy_n;

    logic              found;
    logic [PW-1:0]     win;
    logic [SIZE_W-1:0] win_x, win_y;

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    assign win_x = sizeX_i[int'(win)*SIZE_W +: SIZE_W];
    assign win_y = sizeY_i[int'(win)*SIZE_W +: SIZE_W];

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        wd_n    = wd;
        grant_n = grant_o;
        done_n  = '0;
        err_n   = 1'b0;
        start_n = 1'b0;
        sx_n    = conv_sizeX_o;
        sy_n    = conv_sizeY_o;
        unique case (state)
            IDLE: begin
                if (|req_i) state_n = ARB;
            end
            ARB: begin
                if (found) begin
                    grant_n = NREQ'(1) << win;
                    sx_n    = win_x;
                    sy_n    = win_y;
                    rr_n    = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
                    if (win_x == '0 || win_y == '0) state_n = REJECT;
                    else                            state_n = LAUNCH;
                end else begin
                    state_n = IDLE;
                end
            end
            LAUNCH: begin
                if (!conv_busy_i) begin
                    start_n = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                wd_n = wd + 1'b1;
                // A done arriving on the last watchdog cycle still counts.
                if (conv_done_i)         state_n = FINISH;
                else if (wd == WD_LAST)  state_n = TIMEOUT;
            end
            FINISH: begin
                done_n  = grant_o;
                grant_n = '0;
                wd_n    = '0;
                state_n = IDLE;
            end
            REJECT, TIMEOUT: begin
                done_n  = grant_o;
                err_n   = 1'b1;
                grant_n = '0;
                wd_n    = '0;
                state_n = IDLE;
            end
            default: begin
                grant_n = '0;
                wd_n    = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            wd           <= '0;
            grant_o      <= '0;
            done_o       <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            conv_start_o <= 1'b0;
            conv_sizeX_o <= '0;
            conv_sizeY_o <= '0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_n;
            wd           <= wd_n;
            grant_o      <= grant_n;
            done_o       <= done_n;
            err_o        <= err_n;
            busy_o       <= busy_n;
            conv_start_o <= start_n;
            conv_sizeX_o <= sx_n;
            conv_sizeY_o <= sy_n;
        end
    end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: one default instance plus a
// short-watchdog instance (TMO_W=4) for the timeout scenarios.
module tb_conv_job_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, req_t;
    logic [9:0] sx, sy;
    logic [1:0] grant, done, grant_t, done_t;
    logic       err, busy, start, err_t, busy_t, start_t;
    logic [4:0] cx, cy, cx_t, cy_t;
    logic       cbusy, cdone, cbusy_t, cdone_t;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv_job_scheduler #(.NREQ(2), .SIZE_W(5), .TMO_W(12)) dut (
        .clk(clk), .rst(rst), .req_i(req), .sizeX_i(sx), .sizeY_i(sy),
        .grant_o(grant), .done_o(done), .err_o(err), .busy_o(busy),
        .conv_start_o(start), .conv_sizeX_o(cx), .conv_sizeY_o(cy),
        .conv_busy_i(cbusy), .conv_done_i(cdone)
    );

    conv_job_scheduler #(.NREQ(2), .SIZE_W(5), .TMO_W(4)) dut_t (
        .clk(clk), .rst(rst), .req_i(req_t), .sizeX_i(sx), .sizeY_i(sy),
        .grant_o(grant_t), .done_o(done_t), .err_o(err_t), .busy_o(busy_t),
        .conv_start_o(start_t), .conv_sizeX_o(cx_t), .conv_sizeY_o(cy_t),
        .conv_busy_i(cbusy_t), .conv_done_i(cdone_t)
    );

    task automatic test_reset();
        rst = 1'b1;
        req = '0; req_t = '0;
        sx = {5'd2, 5'd5};
        sy = {5'd4, 5'd3};
        cbusy = 1'b0; cdone = 1'b0;
        cbusy_t = 1'b0; cdone_t = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({grant, done, err, busy, start, cx, cy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0",
                     {grant, done, err, busy, start, cx, cy});
        end
        n_cmp++;
        if ({grant_t, done_t, err_t, busy_t, start_t, cx_t, cy_t} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_t: got %b want 0",
                     {grant_t, done_t, err_t, busy_t, start_t, cx_t, cy_t});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        req = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (start !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_start k=%0d: got %b want %b", k, start, k == 3);
            end
        end
        n_cmp++;
        if ({grant, cx, cy, busy} !== {2'b01, 5'd5, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL single_launch: grant=%b cx=%0d cy=%0d busy=%b want 01/5/3/1",
                     grant, cx, cy, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({start, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL single_run k=%0d: start=%b done=%b want 0/00", k, start, done);
            end
        end
        cdone = 1'b1;
        @(negedge clk);
        cdone = 1'b0;
        n_cmp++;
        if (done !== 2'b00) begin
            n_fail++;
            $display("FAIL single_finish_early: got %b want 00", done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, busy, grant} !== {2'b01, 1'b0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL single_done: done=%b err=%b busy=%b grant=%b want 01/0/0/00",
                     done, err, busy, grant);
        end
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done_width: got %b want 00", done);
        end
    endtask

    task automatic test_zero_size();
        sx = {5'd0, 5'd5};
        req = 2'b10;
        @(negedge clk);
        n_cmp++;
        if ({busy, start} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_arb: busy=%b start=%b want 1/0", busy, start);
        end
        @(negedge clk);
        n_cmp++;
        if ({grant, done, start} !== {2'b10, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_reject: grant=%b done=%b start=%b want 10/00/0",
                     grant, done, start);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, start, busy} !== {2'b10, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_done: done=%b err=%b start=%b busy=%b want 10/1/0/0",
                     done, err, start, busy);
        end
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({done, err, start} !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_after: done=%b err=%b start=%b want 00/0/0", done, err, start);
        end
        sx = {5'd2, 5'd5};
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0] exp_x [4] = '{5'd5, 5'd2, 5'd5, 5'd2};
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            int t = 0;
            while (start !== 1'b1 && t < 10) begin
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (start !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_start_timeout job=%0d: start=%b want 1", j, start);
            end
            n_cmp++;
            if ({grant, cx} !== {exp_g[j], exp_x[j]}) begin
                n_fail++;
                $display("FAIL fair_grant job=%0d: grant=%b cx=%0d want %b/%0d",
                         j, grant, cx, exp_g[j], exp_x[j]);
            end
            cdone = 1'b1;
            @(negedge clk);
            cdone = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({done, err} !== {exp_g[j], 1'b0}) begin
                n_fail++;
                $display("FAIL fair_done job=%0d: done=%b err=%b want %b/0",
                         j, done, err, exp_g[j]);
            end
            if (j == 3) req = 2'b00;
        end
        @(negedge clk);
    endtask

    task automatic test_busy_holdoff();
        cbusy = 1'b1;
        req = 2'b01;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({grant, start} !== 3'b010) begin
            n_fail++;
            $display("FAIL hold_launch: grant=%b start=%b want 01/0", grant, start);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (start !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_wait k=%0d: start=%b want 0", k, start);
            end
        end
        cbusy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_start: got %b want 1", start);
        end
        cdone = 1'b1;
        @(negedge clk);
        cdone = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 3'b010) begin
            n_fail++;
            $display("FAIL hold_done: done=%b err=%b want 01/0", done, err);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        req_t = 2'b01;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (start_t !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_start: got %b want 1", start_t);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 16 && done_t !== 2'b00) begin
                n_fail++;
                $display("FAIL tmo_early k=%0d: done=%b want 00", k, done_t);
            end else if (k == 16 && {done_t, err_t} !== 3'b011) begin
                n_fail++;
                $display("FAIL tmo_done: done=%b err=%b want 01/1", done_t, err_t);
            end
        end
        req_t = 2'b00;
        @(negedge clk);
        // Next job: processor answers on the very last watchdog cycle.
        req_t = 2'b01;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start_t, grant_t} !== 3'b101) begin
            n_fail++;
            $display("FAIL tmo_next_start: start=%b grant=%b want 1/01", start_t, grant_t);
        end
        repeat (14) @(negedge clk);
        cdone_t = 1'b1;
        @(negedge clk);
        cdone_t = 1'b0;
        n_cmp++;
        if (done_t !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_coinc_early: done=%b want 00", done_t);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_t, err_t} !== 3'b010) begin
            n_fail++;
            $display("FAIL tmo_coinc_done: done=%b err=%b want 01/0", done_t, err_t);
        end
        req_t = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        req = 2'b01;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_start: got %b want 1", start);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({grant, done, err, busy, start, cx, cy} !== 19'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got %b want 0",
                     {grant, done, err, busy, start, cx, cy});
        end
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_nodone: done=%b busy=%b want 00/0", done, busy);
        end
        req = 2'b01;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start, grant, cx} !== {1'b1, 2'b01, 5'd5}) begin
            n_fail++;
            $display("FAIL rmid_fresh: start=%b grant=%b cx=%0d want 1/01/5",
                     start, grant, cx);
        end
        cdone = 1'b1;
        @(negedge clk);
        cdone = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 3'b010) begin
            n_fail++;
            $display("FAIL rmid_done: done=%b err=%b want 01/0", done, err);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_zero_size();
        test_fairness();
        test_busy_holdoff();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
